vn_stoch: RTL and testbench

- Stochastic variable node (VN) for the bit-serial LDPC decoder; sits directly upstream of the parity check node.
- Each cycle it drives one stochastic bit per edge (Q) to the connected PCNs and consumes their extrinsic bits (R).
- Per-edge edge memories (EM) break latching when inputs disagree.
- A saturating up/down counter produces the hard-decision bit for the codeword output.

---
 rtl/vn_stoch_if.sv | 24 ++
 rtl/vn_stoch.sv | 64 ++++++
 tb/tb_vn_stoch.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/vn_stoch_if.sv
// Bus bundle between a stochastic variable node and its driver:
// enable, channel bit, PCN extrinsic bits and EM read address in,
// per-edge messages and hard decision out.
interface vn_stoch_if #(
    parameter int DV  = 3,
    parameter int A_W = 3
);
    logic           EN;
    logic           CH;
    logic [DV-1:0]  R;
    logic [A_W-1:0] ADDR;
    logic [DV-1:0]  Q;
    logic           DEC;

    modport master (
        output EN, CH, R, ADDR,
        input  Q, DEC
    );

    modport slave (
        input  EN, CH, R, ADDR,
        output Q, DEC
    );
endinterface

// File: rtl/vn_stoch.sv
// Stochastic variable node: per-edge regenerate/hold messaging with edge
// memories to break latching, plus a saturating counter for the hard decision.
module vn_stoch #(
    parameter int DV    = 3,
    parameter int A_W   = 3,
    parameter int CNT_W = 4
) (
    input  logic      CLK,
    input  logic      RST,
    vn_stoch_if.slave bus
);
    localparam int EM_D = 1 << A_W;
    localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [EM_D-1:0]  em [DV];
    logic [DV-1:0]    q_reg;
    logic [CNT_W-1:0] cnt;

    logic [DV-1:0]    regen;
    logic [DV-1:0]    q_next;
    logic             all_one;
    logic             all_zero;

    // Per edge: regenerate when the channel bit and every other edge's R agree,
    // otherwise replay a randomly addressed bit from that edge's memory.
    always_comb begin
        regen    = '0;
        q_next   = '0;
        all_one  = bus.CH & (&bus.R);
        all_zero = ~bus.CH & ~(|bus.R);
        for (int e = 0; e < DV; e++) begin
            if (bus.CH)
                regen[e] = &(bus.R | (DV'(1) << e));
            else
                regen[e] = ~(|(bus.R & ~(DV'(1) << e)));
            q_next[e] = regen[e] ? bus.CH : em[e][bus.ADDR];
        end
    end

    // State update: reset clears everything, EN=0 freezes, otherwise advance.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_reg <= '0;
            cnt   <= CNT_INIT;
            for (int e = 0; e < DV; e++)
                em[e] <= '0;
        end else if (bus.EN) begin
            q_reg <= q_next;
            for (int e = 0; e < DV; e++) begin
                if (regen[e])
                    em[e] <= {em[e][EM_D-2:0], bus.CH};
            end
            if (all_one && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            else if (all_zero && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    assign bus.Q   = q_reg;
    assign bus.DEC = cnt[CNT_W-1];

endmodule

// File: tb/tb_vn_stoch.sv
// Self-checking bench for vn_stoch: directed scenarios followed by random
// stimulus, all compared every cycle against a behavioural model.
module tb_vn_stoch;
    localparam int DV    = 3;
    localparam int A_W   = 3;
    localparam int CNT_W = 4;
    localparam int EM_D  = 1 << A_W;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int CNT_INIT = (1 << (CNT_W - 1)) - 1;

    logic CLK;
    logic RST;

    vn_stoch_if #(.DV(DV), .A_W(A_W)) bus ();

    vn_stoch #(.DV(DV), .A_W(A_W), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 0;

    // Behavioural model state
    bit          em_m [DV][EM_D];
    bit [DV-1:0] q_m;
    int          cnt_m;

    // Advance the model by one rising edge using the values that were applied.
    task automatic model_step(input bit rst, input bit en, input bit ch,
                              input bit [DV-1:0] r, input bit [A_W-1:0] addr);
        bit same;
        int ones;
        if (rst) begin
            q_m   = '0;
            cnt_m = CNT_INIT;
            for (int e = 0; e < DV; e++)
                for (int i = 0; i < EM_D; i++)
                    em_m[e][i] = 1'b0;
        end else if (en) begin
            for (int e = 0; e < DV; e++) begin
                same = 1'b1;
                for (int k = 0; k < DV; k++)
                    if (k != e && r[k] != ch) same = 1'b0;
                if (same) begin
                    q_m[e] = ch;
                    for (int i = EM_D - 1; i > 0; i--)
                        em_m[e][i] = em_m[e][i-1];
                    em_m[e][0] = ch;
                end else begin
                    q_m[e] = em_m[e][addr];
                end
            end
            ones = int'(ch);
            for (int k = 0; k < DV; k++) ones += int'(r[k]);
            if (ones == DV + 1 && cnt_m < CNT_MAX) cnt_m++;
            else if (ones == 0 && cnt_m > 0) cnt_m--;
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, update the model,
    // and return at the following falling edge.
    task automatic apply_stimulus(input bit rst, input bit en, input bit ch,
                                  input bit [DV-1:0] r, input bit [A_W-1:0] addr);
        RST      = rst;
        bus.EN   = en;
        bus.CH   = ch;
        bus.R    = r;
        bus.ADDR = addr;
        @(posedge CLK);
        model_step(rst, en, ch, r, addr);
        chk_en = 1'b1;
        @(negedge CLK);
    endtask

    // Hand-computed expectation check.
    task automatic check_output(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle after the first reset edge the outputs must match the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            vectors++;
            if (bus.Q !== q_m) begin
                miscompares++;
                $display("[TB] FAIL model_q: got %b, expected %b at %0t", bus.Q, q_m, $time);
            end
            vectors++;
            if (bus.DEC !== (cnt_m >= (1 << (CNT_W - 1)))) begin
                miscompares++;
                $display("[TB] FAIL model_dec: got %b, expected %b (cnt %0d) at %0t",
                         bus.DEC, (cnt_m >= (1 << (CNT_W - 1))), cnt_m, $time);
            end
        end
    end

    initial begin
        bit [7:0]    pat;
        bit          b;
        bit [DV-1:0] rr;
        bit          cc;
        int          flip;

        RST = 1'b1; bus.EN = 1'b0; bus.CH = 1'b0; bus.R = '0; bus.ADDR = '0;
        @(negedge CLK);

        // Reset with EN=1 and all-ones inputs, then frozen cycles.
        for (int i = 0; i < 3; i++) apply_stimulus(1, 1, 1, 3'b111, 3'd0);
        check_output("reset_q", int'(bus.Q), 0);
        check_output("reset_dec", int'(bus.DEC), 0);
        check_output("reset_cnt_model", cnt_m, 7);
        for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 1, 3'b111, 3'(i));
        check_output("hold_en0_q", int'(bus.Q), 0);
        check_output("hold_en0_dec", int'(bus.DEC), 0);

        // Regeneration with all ones: counter climbs and saturates.
        apply_stimulus(0, 1, 1, 3'b111, 3'd0);
        check_output("regen_first_q", int'(bus.Q), 7);
        check_output("regen_first_dec", int'(bus.DEC), 1);
        check_output("regen_first_cnt_model", cnt_m, 8);
        for (int i = 0; i < 9; i++) apply_stimulus(0, 1, 1, 3'b111, 3'(i));
        check_output("regen_sat_q", int'(bus.Q), 7);
        check_output("regen_sat_dec", int'(bus.DEC), 1);
        check_output("regen_sat_cnt_model", cnt_m, 15);

        // Preload EM_0 with index 0..7 = 1,0,1,1,0,0,1,0 (oldest shifted in first).
        pat = 8'b0100_1101;
        for (int i = 7; i >= 0; i--) begin
            b = pat[i];
            apply_stimulus(0, 1, b, {DV{b}}, 3'd0);
        end
        // Disagreeing inputs on every edge: sweep the read address.
        for (int a = 0; a < EM_D; a++) begin
            apply_stimulus(0, 1, 1, 3'b010, 3'(a));
            check_output($sformatf("hold_em0_addr%0d", a), int'(bus.Q[0]), int'(pat[a]));
        end
        // Sweep again to show the hold path left EM_0 untouched.
        for (int a = EM_D - 1; a >= 0; a--) begin
            apply_stimulus(0, 1, 1, 3'b010, 3'(a));
            check_output($sformatf("hold_em0_again%0d", a), int'(bus.Q[0]), int'(pat[a]));
        end

        // Mixed: edge 0 regenerates to 0, edges 1 and 2 hold.
        apply_stimulus(0, 1, 0, 3'b001, 3'd5);
        check_output("mixed_q0", int'(bus.Q[0]), 0);

        // Saturation low from reset.
        apply_stimulus(1, 1, 0, 3'b000, 3'd0);
        for (int i = 0; i < 10; i++) apply_stimulus(0, 1, 0, 3'b000, 3'(i));
        check_output("sat_low_cnt_model", cnt_m, 0);
        check_output("sat_low_dec", int'(bus.DEC), 0);
        check_output("sat_low_q", int'(bus.Q), 0);

        // Mid-frame reset after filling with ones.
        for (int i = 0; i < 10; i++) apply_stimulus(0, 1, 1, 3'b111, 3'(i));
        check_output("prefill_dec", int'(bus.DEC), 1);
        apply_stimulus(1, 1, 1, 3'b111, 3'd3);
        check_output("midrst_q", int'(bus.Q), 0);
        check_output("midrst_dec", int'(bus.DEC), 0);
        check_output("midrst_cnt_model", cnt_m, 7);
        for (int a = 0; a < EM_D; a++) begin
            apply_stimulus(0, 1, 1, 3'b010, 3'(a));
            check_output($sformatf("midrst_em_clear%0d", a), int'(bus.Q), 0);
        end

        // Random phase, biased so regeneration and disagreement both occur often.
        for (int n = 0; n < 600; n++) begin
            cc = 1'($urandom_range(0, 1));
            rr = {DV{cc}};
            flip = $urandom_range(0, DV + 1);
            if (flip < DV) rr[flip] = ~rr[flip];
            if ($urandom_range(0, 3) == 0) rr = DV'($urandom);
            apply_stimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
                           cc, rr, A_W'($urandom));
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
